// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder state encoding, default device ID and
// bit-position constants used by both the responder and the SCCB master.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_ACK    = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_DATA      = 4'd5,
        ST_DATA_ACK  = 4'd6,
        ST_RD_BYTE   = 4'd7,
        ST_RD_NA     = 4'd8,
        ST_WAIT_STOP = 4'd9
    } sccb_state_e;

    localparam logic [7:0] SCCB_DEV_ID   = 8'h42;
    // Bit counter value while the last data bit is sampled / the ninth (ACK/NA) bit slot
    localparam logic [3:0] SCCB_LAST_BIT = 4'd7;
    localparam logic [3:0] SCCB_ACK_BIT  = 4'd8;

    function automatic logic [7:0] sccb_read_id(input logic [7:0] wr_id);
        return wr_id | 8'h01;
    endfunction

endpackage

// File: rtl/sccb_bus_sync.sv
// Synchronises sioc/siod into the clk domain and emits registered single-cycle
// start, stop and sioc rise/fall events plus the synchronised siod level.
module sccb_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic sioc_in,
    input  logic siod_in,
    output logic sioc_rise,
    output logic sioc_fall,
    output logic start_det,
    output logic stop_det,
    output logic siod_lvl
);

    // Stage [0],[1] form the synchronizer, [2] is the delayed copy for edge detect
    logic [2:0] sioc_sync_r;
    logic [2:0] siod_sync_r;

    // Shift both lines in and register the edge events; reset to the idle-high bus
    always_ff @(posedge clk) begin
        if (rst) begin
            sioc_sync_r <= 3'b111;
            siod_sync_r <= 3'b111;
            sioc_rise   <= 1'b0;
            sioc_fall   <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            siod_lvl    <= 1'b1;
        end else begin
            sioc_sync_r <= {sioc_sync_r[1:0], sioc_in};
            siod_sync_r <= {siod_sync_r[1:0], siod_in};
            sioc_rise   <= sioc_sync_r[1] & ~sioc_sync_r[2];
            sioc_fall   <= ~sioc_sync_r[1] & sioc_sync_r[2];
            start_det   <= sioc_sync_r[1] & ~siod_sync_r[1] & siod_sync_r[2];
            stop_det    <= sioc_sync_r[1] & siod_sync_r[1] & ~siod_sync_r[2];
            siod_lvl    <= siod_sync_r[1];
        end
    end

endmodule

// File: rtl/sccb_target.sv
// SCCB responder: decodes 3-phase writes and 2-phase reads, strobes register
// writes and serialises reads from an external register file onto open-drain siod.
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID  = SCCB_DEV_ID,
    parameter bit         ACK_EN  = 1'b1,
    parameter logic [7:0] SUB_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       id_err
);

    sccb_state_e state_r, state_nxt_s;
    logic [3:0]  bit_cnt_r, bit_cnt_nxt_s, cnt_inc_s;
    logic [7:0]  shift_r, shift_nxt_s, byte_s;
    logic        ack_ph_r, ack_ph_nxt_s;
    logic        is_read_r, is_read_nxt_s;
    logic [7:0]  rd_addr_r, rd_addr_nxt_s;
    logic [7:0]  wr_addr_r, wr_addr_nxt_s;
    logic [7:0]  wr_data_r, wr_data_nxt_s;
    logic        wr_en_r, wr_en_nxt_s;
    logic        oe_r, oe_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        id_err_r, id_err_nxt_s;
    logic        rise_s, fall_s, start_s, stop_s, sda_s;

    sccb_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sioc_in   (sioc_in),
        .siod_in   (siod_in),
        .sioc_rise (rise_s),
        .sioc_fall (fall_s),
        .start_det (start_s),
        .stop_det  (stop_s),
        .siod_lvl  (sda_s)
    );

    assign cnt_inc_s = (bit_cnt_r == 4'd15) ? 4'd15 : bit_cnt_r + 4'd1;
    assign byte_s    = {shift_r[6:0], sda_s};

    // Next-state and next-output decode; START outranks STOP
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        ack_ph_nxt_s  = ack_ph_r;
        is_read_nxt_s = is_read_r;
        rd_addr_nxt_s = rd_addr_r;
        wr_addr_nxt_s = wr_addr_r;
        wr_data_nxt_s = wr_data_r;
        wr_en_nxt_s   = 1'b0;
        oe_nxt_s      = oe_r;
        busy_nxt_s    = busy_r;
        id_err_nxt_s  = 1'b0;

        if (start_s) begin
            state_nxt_s   = ST_ID;
            bit_cnt_nxt_s = 4'd0;
            busy_nxt_s    = 1'b1;
            oe_nxt_s      = 1'b0;
            ack_ph_nxt_s  = 1'b0;
        end else if (stop_s) begin
            state_nxt_s  = ST_IDLE;
            busy_nxt_s   = 1'b0;
            oe_nxt_s     = 1'b0;
            ack_ph_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_ID, ST_SUB, ST_DATA: begin
                    if (rise_s) begin
                        shift_nxt_s   = byte_s;
                        bit_cnt_nxt_s = cnt_inc_s;
                        if (bit_cnt_r == SCCB_LAST_BIT) begin
                            ack_ph_nxt_s = 1'b0;
                            if (state_r == ST_SUB) begin
                                rd_addr_nxt_s = byte_s;
                                state_nxt_s   = ST_SUB_ACK;
                            end else if (state_r == ST_DATA) begin
                                wr_addr_nxt_s = rd_addr_r;
                                wr_data_nxt_s = byte_s;
                                wr_en_nxt_s   = 1'b1;
                                state_nxt_s   = ST_DATA_ACK;
                            end else if (byte_s == DEV_ID) begin
                                is_read_nxt_s = 1'b0;
                                state_nxt_s   = ST_ID_ACK;
                            end else if (byte_s == sccb_read_id(DEV_ID)) begin
                                is_read_nxt_s = 1'b1;
                                state_nxt_s   = ST_ID_ACK;
                            end else begin
                                id_err_nxt_s = 1'b1;
                                state_nxt_s  = ST_WAIT_STOP;
                            end
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                // First fall opens the ACK window, second fall closes it
                ST_ID_ACK, ST_SUB_ACK, ST_DATA_ACK: begin
                    if (fall_s) begin
                        if (!ack_ph_r) begin
                            ack_ph_nxt_s = 1'b1;
                            oe_nxt_s     = ACK_EN;
                        end else begin
                            ack_ph_nxt_s  = 1'b0;
                            oe_nxt_s      = 1'b0;
                            bit_cnt_nxt_s = 4'd0;
                            if (state_r == ST_SUB_ACK) begin
                                state_nxt_s = ST_DATA;
                            end else if (state_r == ST_DATA_ACK) begin
                                state_nxt_s = ST_WAIT_STOP;
                            end else if (is_read_r) begin
                                state_nxt_s = ST_RD_BYTE;
                                shift_nxt_s = {rd_data[6:0], 1'b0};
                                oe_nxt_s    = ~rd_data[7];
                            end else begin
                                state_nxt_s = ST_SUB;
                            end
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_RD_BYTE: begin
                    if (rise_s) begin
                        bit_cnt_nxt_s = cnt_inc_s;
                    end else if (fall_s) begin
                        if (bit_cnt_r == SCCB_ACK_BIT) begin
                            oe_nxt_s    = 1'b0;
                            state_nxt_s = ST_RD_NA;
                        end else begin
                            oe_nxt_s    = ~shift_r[7];
                            shift_nxt_s = {shift_r[6:0], 1'b0};
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_RD_NA: begin
                    oe_nxt_s = 1'b0;
                    if (rise_s) begin
                        state_nxt_s = ST_WAIT_STOP;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    state_nxt_s = state_r;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                    oe_nxt_s    = 1'b0;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            ack_ph_r  <= 1'b0;
            is_read_r <= 1'b0;
            rd_addr_r <= SUB_RST;
            wr_addr_r <= 8'h00;
            wr_data_r <= 8'h00;
            wr_en_r   <= 1'b0;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
            id_err_r  <= 1'b0;
        end else begin
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            ack_ph_r  <= ack_ph_nxt_s;
            is_read_r <= is_read_nxt_s;
            rd_addr_r <= rd_addr_nxt_s;
            wr_addr_r <= wr_addr_nxt_s;
            wr_data_r <= wr_data_nxt_s;
            wr_en_r   <= wr_en_nxt_s;
            oe_r      <= oe_nxt_s;
            busy_r    <= busy_nxt_s;
            id_err_r  <= id_err_nxt_s;
        end
    end

    assign siod_oe = oe_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign rd_addr = rd_addr_r;
    assign busy    = busy_r;
    assign id_err  = id_err_r;

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: a behavioural SCCB master drives two responders
// (ACK enabled and ACK disabled) sharing sioc, each seeing its own open-drain siod.
module tb_sccb_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       sioc;
    logic       siod_drv;
    logic [7:0] rd_data;

    logic       oe0, wr_en0, busy0, id_err0;
    logic [7:0] wr_addr0, wr_data0, rd_addr0;
    logic       oe1, wr_en1, busy1, id_err1;
    logic [7:0] wr_addr1, wr_data1, rd_addr1;
    logic       bus0, bus1;

    assign bus0 = siod_drv & ~oe0;
    assign bus1 = siod_drv & ~oe1;

    always #5 clk = ~clk;

    sccb_target #(.DEV_ID(8'h42), .ACK_EN(1'b1), .SUB_RST(8'h00)) dut (
        .clk(clk), .rst(rst), .sioc_in(sioc), .siod_in(bus0), .siod_oe(oe0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .rd_addr(rd_addr0),
        .rd_data(rd_data), .busy(busy0), .id_err(id_err0)
    );

    sccb_target #(.DEV_ID(8'h42), .ACK_EN(1'b0), .SUB_RST(8'h00)) dut_na (
        .clk(clk), .rst(rst), .sioc_in(sioc), .siod_in(bus1), .siod_oe(oe1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .rd_addr(rd_addr1),
        .rd_data(rd_data), .busy(busy1), .id_err(id_err1)
    );

    int         wr_cnt0 = 0, wr_cnt1 = 0, iderr_cnt0 = 0, oe_cyc0 = 0, oe_cyc1 = 0;
    logic [7:0] last_addr0 = 8'h00, last_data0 = 8'h00;
    logic [7:0] last_addr1 = 8'h00, last_data1 = 8'h00;

    // Event counters sampled on the inactive clock edge
    always @(negedge clk) begin
        if (wr_en0) begin
            wr_cnt0    <= wr_cnt0 + 1;
            last_addr0 <= wr_addr0;
            last_data0 <= wr_data0;
        end
        if (wr_en1) begin
            wr_cnt1    <= wr_cnt1 + 1;
            last_addr1 <= wr_addr1;
            last_data1 <= wr_data1;
        end
        if (id_err0) iderr_cnt0 <= iderr_cnt0 + 1;
        if (oe0)     oe_cyc0    <= oe_cyc0 + 1;
        if (oe1)     oe_cyc1    <= oe_cyc1 + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int half_clk    = 6;
    int quarter_clk = 2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        siod_drv = 1'b1;
        wait_clk(half_clk);
        sioc = 1'b1;
        wait_clk(half_clk);
        siod_drv = 1'b0;
        wait_clk(half_clk);
        sioc = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(quarter_clk);
        siod_drv = 1'b0;
        wait_clk(half_clk - quarter_clk);
        sioc = 1'b1;
        wait_clk(half_clk);
        siod_drv = 1'b1;
        wait_clk(half_clk);
    endtask

    // One bit: data changes in the low phase, siod_oe of the ACK-enabled DUT sampled mid-high
    task automatic send_bit(input logic b, output logic oe_seen);
        wait_clk(quarter_clk);
        siod_drv = b;
        wait_clk(half_clk - quarter_clk);
        sioc = 1'b1;
        wait_clk(half_clk / 2);
        oe_seen = oe0;
        wait_clk(half_clk - half_clk / 2);
        sioc = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
        send_bit(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] oe_bits, output logic na_oe);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            oe_bits[i] = s;
        end
        send_bit(1'b1, na_oe);
    endtask

    task automatic write3(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] dat,
                          output logic [2:0] acks);
        logic a;
        bus_start();
        send_byte(id, a);  acks[2] = a;
        send_byte(sub, a); acks[1] = a;
        send_byte(dat, a); acks[0] = a;
        bus_stop();
    endtask

    logic [7:0] rom_sub [4] = '{8'h12, 8'h11, 8'h3A, 8'h40};
    logic [7:0] rom_dat [4] = '{8'h80, 8'h01, 8'h04, 8'hD0};

    initial begin
        int         w0, w1, e0, o0, o1;
        logic       ack, na;
        logic [2:0] acks;
        logic [7:0] bits;
        logic [7:0] dat;

        rst = 1'b1; sioc = 1'b1; siod_drv = 1'b1; rd_data = 8'h76;
        wait_clk(4);
        check_eq("rst_oe",      oe0,      1'b0);
        check_eq("rst_wr_en",   wr_en0,   1'b0);
        check_eq("rst_wr_addr", wr_addr0, 8'h00);
        check_eq("rst_wr_data", wr_data0, 8'h00);
        check_eq("rst_rd_addr", rd_addr0, 8'h00);
        check_eq("rst_busy",    busy0,    1'b0);
        check_eq("rst_id_err",  id_err0,  1'b0);
        rst = 1'b0;
        wait_clk(4);

        // 1: plain 3-phase write
        w0 = wr_cnt0;
        bus_start();
        wait_clk(1);
        check_eq("t1_busy_mid", busy0, 1'b1);
        send_byte(8'h42, ack); acks[2] = ack;
        send_byte(8'h12, ack); acks[1] = ack;
        send_byte(8'h80, ack); acks[0] = ack;
        bus_stop();
        check_eq("t1_acks",    acks, 3'b111);
        check_eq("t1_busy",    busy0, 1'b0);
        check_eq("t1_wr_cnt",  wr_cnt0 - w0, 1);
        check_eq("t1_wr_addr", last_addr0, 8'h12);
        check_eq("t1_wr_data", last_data0, 8'h80);

        // 2: foreign ID
        w0 = wr_cnt0; e0 = iderr_cnt0; o0 = oe_cyc0;
        bus_start();
        send_byte(8'h60, ack);
        check_eq("t2_id_ack", ack, 1'b0);
        send_byte(8'h12, ack);
        check_eq("t2_byte_ack", ack, 1'b0);
        bus_stop();
        check_eq("t2_id_err", iderr_cnt0 - e0, 1);
        check_eq("t2_wr_cnt", wr_cnt0 - w0, 0);
        check_eq("t2_oe_cyc", oe_cyc0 - o0, 0);
        check_eq("t2_busy",   busy0, 1'b0);

        // 3: 2-phase write sets the sub-address, then a read returns rd_data inverted on siod_oe
        w0 = wr_cnt0;
        bus_start();
        send_byte(8'h42, ack);
        send_byte(8'h0A, ack);
        bus_stop();
        bus_start();
        send_byte(8'h43, ack);
        check_eq("t3_rd_id_ack", ack, 1'b1);
        recv_byte(bits, na);
        bus_stop();
        check_eq("t3_rd_bits",   bits, 8'h89);
        check_eq("t3_na_oe",     na, 1'b0);
        check_eq("t3_rd_addr",   rd_addr0, 8'h0A);
        check_eq("t3_rd_addr_na", rd_addr1, 8'h0A);
        check_eq("t3_wr_cnt",    wr_cnt0 - w0, 0);

        // 4: reset in the middle of the data byte
        w0 = wr_cnt0;
        bus_start();
        send_byte(8'h42, ack);
        send_byte(8'h12, ack);
        dat = 8'hAB;
        for (int i = 7; i >= 4; i--) send_bit(dat[i], ack);
        rst = 1'b1;
        wait_clk(1);
        check_eq("t4_busy",    busy0, 1'b0);
        check_eq("t4_rd_addr", rd_addr0, 8'h00);
        check_eq("t4_wr_addr", wr_addr0, 8'h00);
        check_eq("t4_wr_data", wr_data0, 8'h00);
        check_eq("t4_oe",      oe0, 1'b0);
        rst = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(dat[i], ack);
        send_bit(1'b1, ack);
        check_eq("t4_no_ack", ack, 1'b0);
        bus_stop();
        check_eq("t4_no_strobe", wr_cnt0 - w0, 0);
        write3(8'h42, 8'h3A, 8'h04, acks);
        check_eq("t4_wr_cnt",  wr_cnt0 - w0, 1);
        check_eq("t4_wr_addr2", last_addr0, 8'h3A);
        check_eq("t4_wr_data2", last_data0, 8'h04);

        // 5: repeated START after the sub-address discards the pending write
        w0 = wr_cnt0;
        bus_start();
        send_byte(8'h42, ack);
        send_byte(8'h20, ack);
        write3(8'h42, 8'h11, 8'h01, acks);
        check_eq("t5_acks",    acks, 3'b111);
        check_eq("t5_wr_cnt",  wr_cnt0 - w0, 1);
        check_eq("t5_wr_addr", last_addr0, 8'h11);
        check_eq("t5_wr_data", last_data0, 8'h01);

        // 6: faster master timing, ACK-disabled responder over a small configuration table
        half_clk = 5; quarter_clk = 2;
        w0 = wr_cnt0; w1 = wr_cnt1; o1 = oe_cyc1;
        for (int k = 0; k < 4; k++) begin
            write3(8'h42, rom_sub[k], rom_dat[k], acks);
            check_eq("t6_na_addr", last_addr1, rom_sub[k]);
            check_eq("t6_na_data", last_data1, rom_dat[k]);
            check_eq("t6_ack_addr", last_addr0, rom_sub[k]);
        end
        check_eq("t6_na_wr_cnt", wr_cnt1 - w1, 4);
        check_eq("t6_wr_cnt",    wr_cnt0 - w0, 4);
        check_eq("t6_na_oe_cyc", oe_cyc1 - o1, 0);
        check_eq("t6_na_busy",   busy1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
